tdp_ram: RTL and testbench

- True dual-port synchronous RAM with two fully independent read/write ports, A and B, sharing one storage array and one clock.
- Each port has its own write enable, read enable, address, write data and registered read data.
- Used as the DUT behind the TDP RAM UVC. Driver and monitor sample and drive all signals on the rising clock edge.

---
 rtl/tdp_ram.sv | 61 ++++++
 tb/tb_tdp_ram.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdp_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tdp_ram                                                           |
// | Brief  : True dual-port synchronous RAM. Both ports read-first, A wins     |
// |          write/write collisions, and synchronous reset clears the array.   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tdp_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  we_a,
  input  logic                  re_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic [DATA_WIDTH-1:0] out_a,
  input  logic                  we_b,
  input  logic                  re_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] data_b,
  output logic [DATA_WIDTH-1:0] out_b
);

  localparam int c_DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
  logic [DATA_WIDTH-1:0] r_out_a;
  logic [DATA_WIDTH-1:0] r_out_b;

  // Reads sample the pre-edge array, so same-port and cross-port collisions
  // return old data. Port A's write is scheduled last so it wins a tie.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_out_a <= '0;
      r_out_b <= '0;
      for (int i = 0; i < c_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (re_a) begin
        r_out_a <= r_mem[addr_a];
      end
      if (re_b) begin
        r_out_b <= r_mem[addr_b];
      end
      if (we_b) begin
        r_mem[addr_b] <= data_b;
      end
      if (we_a) begin
        r_mem[addr_a] <= data_a;
      end
    end
  end

  assign out_a = r_out_a;
  assign out_b = r_out_b;

endmodule
`default_nettype wire

// File: tb/tb_tdp_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_tdp_ram                                                        |
// | Brief  : Directed self-checking bench for tdp_ram.                         |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_tdp_ram;

  localparam int c_AW = 10;
  localparam int c_DW = 8;

  logic            clk;
  logic            resetn;
  logic            we_a, re_a, we_b, re_b;
  logic [c_AW-1:0] addr_a, addr_b;
  logic [c_DW-1:0] data_a, data_b;
  logic [c_DW-1:0] out_a, out_b;

  int vectors;
  int miscompares;

  tdp_ram #(.ADDR_WIDTH(c_AW), .DATA_WIDTH(c_DW)) u_dut (
    .clk    (clk),
    .resetn (resetn),
    .we_a   (we_a),
    .re_a   (re_a),
    .addr_a (addr_a),
    .data_a (data_a),
    .out_a  (out_a),
    .we_b   (we_b),
    .re_b   (re_b),
    .addr_b (addr_b),
    .data_b (data_b),
    .out_b  (out_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we_a = 1'b0; re_a = 1'b0; we_b = 1'b0; re_b = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    we_a = 1'b1; re_a = 1'b1; addr_a = 10'h3FF; data_a = 8'hEE;
    we_b = 1'b1; re_b = 1'b1; addr_b = 10'h000; data_b = 8'hDD;
    tick();
    tick();
    vectors++;
    if (out_a !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_out_a: got %h expected 00", out_a);
    end
    vectors++;
    if (out_b !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_out_b: got %h expected 00", out_b);
    end
    resetn = 1'b1;
    idle();
    re_a = 1'b1; addr_a = 10'h3FF;
    re_b = 1'b1; addr_b = 10'h000;
    tick();
    vectors++;
    if (out_a !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mem_3ff: got %h expected 00", out_a);
    end
    vectors++;
    if (out_b !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_mem_000: got %h expected 00", out_b);
    end
    idle();
  endtask

  task automatic test_write_read();
    idle();
    we_a = 1'b1; addr_a = 10'h010; data_a = 8'hA5;
    we_b = 1'b1; addr_b = 10'h3FF; data_b = 8'h5A;
    tick();
    idle();
    re_a = 1'b1; addr_a = 10'h3FF;
    re_b = 1'b1; addr_b = 10'h010;
    tick();
    vectors++;
    if (out_a !== 8'h5A) begin
      miscompares++;
      $display("FAIL wr_rd_a: got %h expected 5a", out_a);
    end
    vectors++;
    if (out_b !== 8'hA5) begin
      miscompares++;
      $display("FAIL wr_rd_b: got %h expected a5", out_b);
    end
    idle();
    addr_a = 10'h000; addr_b = 10'h000;
    tick();
    tick();
    vectors++;
    if (out_a !== 8'h5A) begin
      miscompares++;
      $display("FAIL hold_a: got %h expected 5a", out_a);
    end
    vectors++;
    if (out_b !== 8'hA5) begin
      miscompares++;
      $display("FAIL hold_b: got %h expected a5", out_b);
    end
  endtask

  task automatic test_read_first();
    idle();
    we_a = 1'b1; addr_a = 10'h020; data_a = 8'h11;
    tick();
    we_a = 1'b1; re_a = 1'b1; addr_a = 10'h020; data_a = 8'h22;
    tick();
    vectors++;
    if (out_a !== 8'h11) begin
      miscompares++;
      $display("FAIL read_first_old: got %h expected 11", out_a);
    end
    idle();
    re_a = 1'b1;
    tick();
    vectors++;
    if (out_a !== 8'h22) begin
      miscompares++;
      $display("FAIL read_first_new: got %h expected 22", out_a);
    end
    idle();
  endtask

  task automatic test_cross_collision();
    idle();
    we_b = 1'b1; addr_b = 10'h040; data_b = 8'h33;
    tick();
    idle();
    we_a = 1'b1; addr_a = 10'h040; data_a = 8'h44;
    re_b = 1'b1; addr_b = 10'h040;
    tick();
    vectors++;
    if (out_b !== 8'h33) begin
      miscompares++;
      $display("FAIL cross_old: got %h expected 33", out_b);
    end
    idle();
    re_b = 1'b1;
    tick();
    vectors++;
    if (out_b !== 8'h44) begin
      miscompares++;
      $display("FAIL cross_new: got %h expected 44", out_b);
    end
    idle();
  endtask

  task automatic test_write_collision();
    idle();
    we_a = 1'b1; addr_a = 10'h055; data_a = 8'h77;
    we_b = 1'b1; addr_b = 10'h055; data_b = 8'h88;
    tick();
    idle();
    re_a = 1'b1; addr_a = 10'h055;
    re_b = 1'b1; addr_b = 10'h055;
    tick();
    vectors++;
    if (out_a !== 8'h77) begin
      miscompares++;
      $display("FAIL ww_prio_a: got %h expected 77", out_a);
    end
    vectors++;
    if (out_b !== 8'h77) begin
      miscompares++;
      $display("FAIL ww_prio_b: got %h expected 77", out_b);
    end
    // Different addresses on the same edge: both writes land.
    idle();
    we_a = 1'b1; addr_a = 10'h060; data_a = 8'h01;
    we_b = 1'b1; addr_b = 10'h061; data_b = 8'h02;
    tick();
    idle();
    re_a = 1'b1; addr_a = 10'h061;
    re_b = 1'b1; addr_b = 10'h060;
    tick();
    vectors++;
    if (out_a !== 8'h02) begin
      miscompares++;
      $display("FAIL ww_diff_a: got %h expected 02", out_a);
    end
    vectors++;
    if (out_b !== 8'h01) begin
      miscompares++;
      $display("FAIL ww_diff_b: got %h expected 01", out_b);
    end
    idle();
  endtask

  task automatic test_mid_reset();
    logic [c_DW-1:0] exp_v;
    idle();
    for (int i = 0; i < 8; i++) begin
      we_a = 1'b1; addr_a = 10'(i);     data_a = 8'(8'h80 + i);
      we_b = 1'b1; addr_b = 10'(i + 8); data_b = 8'(8'hC0 + i);
      tick();
    end
    idle();
    re_a = 1'b1; addr_a = 10'h003;
    re_b = 1'b1; addr_b = 10'h00C;
    tick();
    vectors++;
    if (out_a !== 8'h83) begin
      miscompares++;
      $display("FAIL fill_a: got %h expected 83", out_a);
    end
    vectors++;
    if (out_b !== 8'hC4) begin
      miscompares++;
      $display("FAIL fill_b: got %h expected c4", out_b);
    end
    resetn = 1'b0;
    tick();
    vectors++;
    if (out_a !== 8'h00 || out_b !== 8'h00) begin
      miscompares++;
      $display("FAIL midrst_out: got a=%h b=%h expected 00/00", out_a, out_b);
    end
    resetn = 1'b1;
    exp_v = 8'h00;
    for (int i = 0; i < 16; i++) begin
      re_a = 1'b1; addr_a = 10'(i);
      re_b = 1'b1; addr_b = 10'(15 - i);
      tick();
      vectors++;
      if (out_a !== exp_v || out_b !== exp_v) begin
        miscompares++;
        $display("FAIL midrst_mem[%0d]: got a=%h b=%h expected 00", i, out_a, out_b);
      end
    end
    idle();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn = 1'b0;
    idle();
    addr_a = '0; addr_b = '0; data_a = '0; data_b = '0;
    #2;
    test_reset();
    test_write_read();
    test_read_first();
    test_cross_collision();
    test_write_collision();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
